mult_div_unit: RTL and testbench

//   Iterative HI/LO multiply/divide unit downstream of the register file. It consumes the rs/rt

---
 rtl/mult_div_unit.sv | 176 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide on
// magnitudes, with a final sign-fix cycle before HI/LO are written.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // state  | meaning
  // IDLE   | waiting for start; MTHI/MTLO complete here
  // CALC   | one multiply/divide iteration per cycle
  // SIGN   | apply result signs, write HI/LO, pulse done
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_SIGN = 2'd2;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0]   ONE  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE2 = (2 * WIDTH)'(1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic [WIDTH-1:0] mul_addend;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   div_diff;
  logic [2*WIDTH-1:0] prod, prod_neg;

  assign rs_neg = op[0] & rs_data[WIDTH-1];
  assign rt_neg = op[0] & rt_data[WIDTH-1];
  assign rs_mag = rs_neg ? (~rs_data + ONE) : rs_data;
  assign rt_mag = rt_neg ? (~rt_data + ONE) : rt_data;

  assign mul_addend = acc_lo_q[0] ? mcand_q : '0;
  assign mul_sum    = {1'b0, acc_hi_q} + {1'b0, mul_addend};
  assign rem_sh     = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_diff   = rem_sh - {1'b0, mcand_q};
  assign prod       = {acc_hi_q, acc_lo_q};
  assign prod_neg   = ~prod + ONE2;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      S_IDLE: begin
        if (start && !op[2]) begin
          state_d   = S_CALC;
          cnt_d     = CW'(WIDTH);
          is_div_d  = op[1];
          neg_d     = rs_neg ^ rt_neg;
          neg_rem_d = rs_neg;
          dz_d      = op[1] && (rt_data == '0);
          dbz_d     = 1'b0;
          mcand_d   = rt_mag;
          acc_hi_d  = '0;
          // With a zero divisor the raw dividend shifts straight into the remainder.
          acc_lo_d  = (op[1] && (rt_data == '0)) ? rs_data : rs_mag;
        end else if (start && !op[1]) begin
          if (op[0]) lo_d = rs_data;
          else       hi_d = rs_data;
          done_d = 1'b1;
          dbz_d  = 1'b0;
        end
      end

      S_CALC: begin
        cnt_d = cnt_q - CW'(1);
        if (is_div_q) begin
          if (rem_sh >= {1'b0, mcand_q}) begin
            acc_hi_d = div_diff[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi_d = rem_sh[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(1)) state_d = S_SIGN;
      end

      S_SIGN: begin
        if (!is_div_q) begin
          {hi_d, lo_d} = neg_q ? prod_neg : prod;
        end else if (dz_q) begin
          hi_d = acc_hi_q;
          lo_d = acc_lo_q;
        end else begin
          lo_d = neg_q     ? (~acc_lo_q + ONE) : acc_lo_q;
          hi_d = neg_rem_q ? (~acc_hi_q + ONE) : acc_hi_q;
        end
        dbz_d   = dz_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      dbz_q     <= dbz_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed HI/LO results, latency, busy/done
// timing, divide-by-zero, ignored requests and mid-operation reset.
module tb_mult_div_unit;

  localparam int W = 32;
  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_NONE  = 3'b111;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] rs_data, rt_data;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance one rising edge, then sample 1ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    tick();
    start   = 1'b0;
    op      = OP_NONE;
    rs_data = $urandom;
    rt_data = $urandom;
  endtask

  // called right after the start edge; cyc = edges from start edge to done
  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = 0;
    while (!done && cyc < 100) begin
      if (busy) bcnt++;
      tick();
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo, input logic exp_dz);
    int cyc, bcnt;
    start_op(o, a, b);
    wait_done(cyc, bcnt);
    check({tag, " latency"}, 64'(cyc), 64'd33);
    check({tag, " hi"}, 64'(hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo), 64'(exp_lo));
    check({tag, " dbz"}, 64'(div_by_zero), 64'(exp_dz));
  endtask

  initial begin
    int cyc, bcnt, dcnt;
    rst_n = 1'b0; start = 1'b1; op = OP_MULTU; rs_data = 32'd5; rt_data = 32'd5;
    tick(); tick();
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset dbz", 64'(div_by_zero), 64'd0);
    rst_n = 1'b1; start = 1'b0;
    tick();

    // 1: full-scale unsigned multiply, latency, busy width, done width
    start_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc, bcnt);
    check("multu max latency", 64'(cyc), 64'd33);
    check("multu max busy cycles", 64'(bcnt), 64'd33);
    check("multu max busy at done", 64'(busy), 64'd0);
    check("multu max hi", 64'(hi), 64'hFFFF_FFFE);
    check("multu max lo", 64'(lo), 64'h0000_0001);
    tick();
    check("done one cycle", 64'(done), 64'd0);

    // 2: hi/lo hold during calc, signed vs unsigned multiply
    start_op(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    for (int i = 0; i < 10; i++) tick();
    check("hold hi in calc", 64'(hi), 64'hFFFF_FFFE);
    check("hold lo in calc", 64'(lo), 64'h0000_0001);
    wait_done(cyc, bcnt);
    check("mult -3*7 latency", 64'(cyc + 10), 64'd33);
    check("mult -3*7 hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult -3*7 lo", 64'(lo), 64'hFFFF_FFEB);
    run_op("multu fffffffd*7", OP_MULTU, 32'hFFFF_FFFD, 32'd7, 32'h6, 32'hFFFF_FFEB, 1'b0);

    // 3: division
    run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);

    // 4: divide by zero, raw dividend, clear on next start, overflow case
    run_op("div 5/0", OP_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
    run_op("div -6/0", OP_DIV, 32'hFFFF_FFFA, 32'd0, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 1'b1);
    start_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("dbz cleared by start", 64'(div_by_zero), 64'd0);
    wait_done(cyc, bcnt);
    check("div ovf latency", 64'(cyc), 64'd33);
    check("div ovf hi", 64'(hi), 64'd0);
    check("div ovf lo", 64'(lo), 64'h8000_0000);

    // 5: start while busy ignored, back-to-back start on done cycle
    start_op(OP_MULTU, 32'd2, 32'd3);
    for (int i = 0; i < 4; i++) tick();
    start = 1'b1; op = OP_MULT; rs_data = 32'd9; rt_data = 32'd9;
    tick();
    start = 1'b0; op = OP_NONE;
    wait_done(cyc, bcnt);
    check("ignored start latency", 64'(cyc + 5), 64'd33);
    check("ignored start hi", 64'(hi), 64'd0);
    check("ignored start lo", 64'(lo), 64'd6);
    start = 1'b1; op = OP_DIVU; rs_data = 32'd100; rt_data = 32'd7;
    tick();
    start = 1'b0; op = OP_NONE; rs_data = 32'd0; rt_data = 32'd0;
    check("b2b busy", 64'(busy), 64'd1);
    check("b2b done low", 64'(done), 64'd0);
    wait_done(cyc, bcnt);
    check("b2b latency", 64'(cyc), 64'd33);
    check("b2b lo", 64'(lo), 64'd14);
    check("b2b hi", 64'(hi), 64'd2);

    // 6: MTHI / MTLO, ignored op, reset mid-operation
    start_op(OP_MTHI, 32'h1234_5678, 32'd0);
    check("mthi done", 64'(done), 64'd1);
    check("mthi busy", 64'(busy), 64'd0);
    check("mthi hi", 64'(hi), 64'h1234_5678);
    check("mthi lo kept", 64'(lo), 64'd14);
    tick();
    check("mthi done pulse", 64'(done), 64'd0);
    start_op(OP_MTLO, 32'hCAFE_F00D, 32'd0);
    check("mtlo done", 64'(done), 64'd1);
    check("mtlo lo", 64'(lo), 64'hCAFE_F00D);
    check("mtlo hi kept", 64'(hi), 64'h1234_5678);
    start_op(OP_NONE, 32'd1, 32'd1);
    check("op11x busy", 64'(busy), 64'd0);
    check("op11x done", 64'(done), 64'd0);
    check("op11x hi", 64'(hi), 64'h1234_5678);

    start_op(OP_MULT, 32'd9, 32'd9);
    for (int i = 0; i < 9; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort hi", 64'(hi), 64'd0);
    check("abort lo", 64'(lo), 64'd0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dcnt++;
      tick();
    end
    check("abort no done", 64'(dcnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
